fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction memory. Holds the program counter, drives the memory's word address, captures the returned instruction into a registered output slot, and hands it to the decoder over a valid/ready handshake. Next-PC selection covers sequential fetch, external redirects from the execute stage, and, optionally, zero-bubble predecode of J-type jumps.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage: PC register, memory address, registered decoder slot.
// Optional FETCH_JUMP_PREDECODE_EN: redirect fetch on J-type jumps at capture time.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_predicted
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
  logic        out_predicted_q, out_predicted_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        is_jump;
  logic        slot_free;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = redirect_pc & ~32'd3;
  assign slot_free       = !out_valid_q || out_ready;

`ifdef FETCH_JUMP_PREDECODE_EN
  assign is_jump = (mem_inst[31:26] == 6'b000010);
  assign next_pc = is_jump ? {pc_plus4[31:28], mem_inst[25:0], 2'b00} : pc_plus4;
`else
  assign is_jump = 1'b0;
  assign next_pc = pc_plus4;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    out_valid_d     = out_valid_q;
    out_inst_d      = out_inst_q;
    out_pc_d        = out_pc_q;
    out_pc_plus4_d  = out_pc_plus4_q;
    out_predicted_d = out_predicted_q;
    case (state_q)
      BOOT: begin
        state_d     = RUN;
        out_valid_d = 1'b0;
        if (redirect_valid) pc_d = redirect_target;
      end
      RUN: begin
        // Redirect flushes the slot even when the decoder is stalling.
        if (redirect_valid) begin
          pc_d        = redirect_target;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          out_inst_d      = mem_inst;
          out_pc_d        = pc_q;
          out_pc_plus4_d  = pc_plus4;
          out_valid_d     = 1'b1;
          out_predicted_d = is_jump;
          pc_d            = next_pc;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      out_valid_q     <= 1'b0;
      out_inst_q      <= 32'd0;
      out_pc_q        <= 32'd0;
      out_pc_plus4_q  <= 32'd0;
      out_predicted_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      out_valid_q     <= out_valid_d;
      out_inst_q      <= out_inst_d;
      out_pc_q        <= out_pc_d;
      out_pc_plus4_q  <= out_pc_plus4_d;
      out_predicted_q <= out_predicted_d;
    end
  end

  assign mem_addr      = pc_q;
  assign out_valid     = out_valid_q;
  assign out_inst      = out_inst_q;
  assign out_pc        = out_pc_q;
  assign out_pc_plus4  = out_pc_plus4_q;
  assign out_predicted = out_predicted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_predicted;
  logic        jump_at0;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;
  exp_t sb[$];

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic PRED = 1'b1;
`else
  localparam logic PRED = 1'b0;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_inst(mem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_predicted(out_predicted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a, input logic j0);
    if (j0 && a == 32'd0) return 32'h0800_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign mem_inst = mem_model(mem_addr, jump_at0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    exp_t e;
    e.pc = pc; e.inst = mem_model(pc, jump_at0); e.pred = pred;
    sb.push_back(e);
  endtask

  // Pops the next expected slot and compares it against what the DUT shows now.
  task automatic pop_cmp(input string name);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s: scoreboard empty, got out_pc %h", name, out_pc);
      return;
    end
    e = sb.pop_front();
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL %s valid: got %b, expected 1", name, out_valid); end
    compared++;
    if (out_pc !== e.pc) begin mismatched++; $display("FAIL %s pc: got %h, expected %h", name, out_pc, e.pc); end
    compared++;
    if (out_inst !== e.inst) begin mismatched++; $display("FAIL %s inst: got %h, expected %h", name, out_inst, e.inst); end
    compared++;
    if (out_pc_plus4 !== e.pc + 32'd4) begin mismatched++; $display("FAIL %s pc4: got %h, expected %h", name, out_pc_plus4, e.pc + 32'd4); end
    compared++;
    if (out_predicted !== e.pred) begin mismatched++; $display("FAIL %s pred: got %b, expected %b", name, out_predicted, e.pred); end
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; jump_at0 = 1'b0;
    step(); step();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_pc4", out_pc_plus4, 32'd0);
    chk("reset_pred", {31'd0, out_predicted}, 32'd0);
    reset = 1'b1;
    step();
    chk("boot_bubble", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic test_sequential();
    push(32'd0, 1'b0); push(32'd4, 1'b0); push(32'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      pop_cmp("seq");
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", out_pc, 32'd8);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_inst", out_inst, mem_model(32'd8, 1'b0));
      chk("stall_addr", mem_addr, 32'd12);
    end
    out_ready = 1'b1;
    push(32'd12, 1'b0);
    step();
    pop_cmp("after_stall");
  endtask

  task automatic test_redirect_stall();
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", mem_addr, 32'h10);
    redirect_valid = 1'b0; out_ready = 1'b1;
    push(32'h10, 1'b0);
    step();
    pop_cmp("redir_target");
  endtask

  task automatic test_jump();
    jump_at0 = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    chk("jmp_pre_addr", mem_addr, 32'd0);
    redirect_valid = 1'b0;
    push(32'd0, PRED);
    step();
    pop_cmp("jump");
    chk("jump_next_addr", mem_addr, PRED ? 32'h10 : 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    chk("jmp_setup_addr", mem_addr, 32'd0);
    redirect_pc = 32'h40;
    step();
    chk("jmp_redir_wins", mem_addr, 32'h40);
    chk("jmp_redir_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0; jump_at0 = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC, 1'b0);
    step();
    pop_cmp("wrap");
    chk("wrap_pc4", out_pc_plus4, 32'd0);
    chk("wrap_addr", mem_addr, 32'd0);
    push(32'd0, 1'b0);
    step();
    pop_cmp("wrap_next");
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    #2;
    reset = 1'b1; out_ready = 1'b1;
    step();
    chk("reboot_bubble", {31'd0, out_valid}, 32'd0);
    push(32'd0, 1'b0);
    step();
    pop_cmp("reboot_first");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_stall();
    test_jump();
    test_wrap();
    test_reset_midstall();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
